// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg
//  Shared types and defaults for the I/D-cache memory-port arbiter.
//  Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_BEATS = 4;
    localparam int DEF_AW    = 16;
    localparam int DEF_DW    = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
//  rr_pick2
//  Two-way round-robin picker: on a tie, the side that did not win last goes.
//  Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic grant_d,
    output logic grant_valid
);

    assign grant_valid = i_req | d_req;
    assign grant_d     = d_req & (~i_req | ~last_d);

endmodule

`default_nettype wire

// File: rtl/sync_dff.sv
// ============================================================================
//  sync_dff
//  Generic register with synchronous active-high reset to RST_VAL.
//  Rev 1.0
// ============================================================================
`default_nettype none

module sync_dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter
//  Shares one memory port between I-cache fills and D-cache fills/writebacks,
//  sequencing line bursts and routing read data back to the burst owner.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BEATS = DEF_BEATS,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_rvalid,
    output logic [1:0]    i_rbeat,
    output logic          i_done,

    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [1:0]    d_wbeat,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic [1:0]    d_rbeat,
    output logic          d_done,

    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_stall,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rvalid,

    output logic          busy
);

    // Counters must reach BEATS itself, hence one extra bit.
    localparam int            CW        = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0] ALL_BEATS = CW'(BEATS);

    state_t        r_state,     w_state_nxt;
    logic [CW-1:0] r_issue_cnt, w_issue_cnt_nxt;
    logic [CW-1:0] r_ret_cnt,   w_ret_cnt_nxt;
    logic [AW-1:0] r_base,      w_base_nxt;
    logic          r_wr,        w_wr_nxt;
    logic          w_owner_q;
    owner_t        r_owner,     w_owner_nxt;
    logic          r_last_d,    w_last_d_nxt;
    logic          r_busy,      w_busy_nxt;

    logic          w_grant_d;
    logic          w_grant_valid;
    logic          w_in_issue;
    logic          w_in_done;
    logic          w_accept;
    logic          w_ret_fire;
    logic          w_own_d;

    rr_pick2 u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_d      (r_last_d),
        .grant_d     (w_grant_d),
        .grant_valid (w_grant_valid)
    );

    assign r_owner    = owner_t'(w_owner_q);
    assign w_own_d    = (r_owner == OWN_D);
    assign w_in_issue = (r_state == ST_ISSUE);
    assign w_in_done  = (r_state == ST_DONE);
    assign w_accept   = w_in_issue & ~mem_stall;

    // Returns only count for read bursts still collecting data.
    assign w_ret_fire = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN))
                        && !r_wr && mem_rvalid && (r_ret_cnt != ALL_BEATS);

    always_comb begin
        w_state_nxt     = r_state;
        w_issue_cnt_nxt = r_issue_cnt;
        w_ret_cnt_nxt   = r_ret_cnt + CW'(w_ret_fire);
        w_base_nxt      = r_base;
        w_wr_nxt        = r_wr;
        w_owner_nxt     = r_owner;
        w_last_d_nxt    = r_last_d;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt     = ST_ISSUE;
                    w_base_nxt      = w_grant_d ? d_addr : i_addr;
                    w_wr_nxt        = w_grant_d & d_wr;
                    w_owner_nxt     = w_grant_d ? OWN_D : OWN_I;
                    w_issue_cnt_nxt = '0;
                    w_ret_cnt_nxt   = '0;
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    w_issue_cnt_nxt = r_issue_cnt + CW'(1);
                    if (r_issue_cnt == LAST_BEAT) begin
                        // Zero-latency memory can finish the read with the last accept.
                        if (r_wr || (w_ret_cnt_nxt == ALL_BEATS)) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_ret_cnt_nxt == ALL_BEATS) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_last_d_nxt = w_own_d;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    sync_dff #(.WIDTH(2))  u_state_q    (.clk(clk), .rst(rst), .d(w_state_nxt),     .q(r_state));
    sync_dff #(.WIDTH(CW)) u_issue_q    (.clk(clk), .rst(rst), .d(w_issue_cnt_nxt), .q(r_issue_cnt));
    sync_dff #(.WIDTH(CW)) u_ret_q      (.clk(clk), .rst(rst), .d(w_ret_cnt_nxt),   .q(r_ret_cnt));
    sync_dff #(.WIDTH(AW)) u_base_q     (.clk(clk), .rst(rst), .d(w_base_nxt),      .q(r_base));
    sync_dff #(.WIDTH(1))  u_wr_q       (.clk(clk), .rst(rst), .d(w_wr_nxt),        .q(r_wr));
    sync_dff #(.WIDTH(1))  u_owner_q    (.clk(clk), .rst(rst), .d(w_owner_nxt),     .q(w_owner_q));
    sync_dff #(.WIDTH(1))  u_last_d_q   (.clk(clk), .rst(rst), .d(w_last_d_nxt),    .q(r_last_d));
    sync_dff #(.WIDTH(1))  u_busy_q     (.clk(clk), .rst(rst), .d(w_busy_nxt),      .q(r_busy));

    // A stalled beat keeps strobe, address and data because issue_cnt holds.
    assign mem_rd    = w_in_issue & ~r_wr;
    assign mem_wr    = w_in_issue &  r_wr;
    assign mem_addr  = w_in_issue ? (r_base + AW'({r_issue_cnt, 1'b0})) : '0;
    assign mem_wdata = w_in_issue ? d_wdata : '0;
    assign d_wbeat   = (w_in_issue && w_own_d) ? r_issue_cnt[1:0] : 2'b00;

    assign i_rvalid  = w_ret_fire & ~w_own_d;
    assign d_rvalid  = w_ret_fire &  w_own_d;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign i_rbeat   = i_rvalid ? r_ret_cnt[1:0] : 2'b00;
    assign d_rbeat   = d_rvalid ? r_ret_cnt[1:0] : 2'b00;

    assign i_done    = w_in_done & ~w_own_d;
    assign d_done    = w_in_done &  w_own_d;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter
//  Self-checking bench: vector table of bursts plus hand-written sequences.
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_rvalid, d_rvalid, i_done, d_done;
    logic [1:0]    i_rbeat, d_rbeat, d_wbeat;
    logic          mem_rd, mem_wr, mem_stall, mem_rvalid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_rbeat(i_rbeat), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wbeat(d_wbeat), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .d_rbeat(d_rbeat), .d_done(d_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no matching event, expected one", name);
    endtask

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:1023];
    logic [9:0]    pipe_a [0:3];
    logic [3:0]    pipe_v;
    logic [DW-1:0] wb_buf [0:3];
    int            lat = 1;
    logic          inj_rv = 1'b0;
    logic [1:0]    lsel;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i >= 32'h20 && i <= 32'h23) return 16'(16'h1111 * (i - 32'h1F));
        return 16'h5A00 ^ 16'(i * 37);
    endfunction

    assign lsel       = (lat == 0) ? 2'd0 : 2'(lat - 1);
    assign d_wdata    = wb_buf[d_wbeat];
    assign mem_rvalid = inj_rv | ((lat == 0) ? (mem_rd & ~mem_stall) : pipe_v[lsel]);
    assign mem_rdata  = inj_rv ? 16'hDEAD :
                        ((lat == 0) ? mem[mem_addr[10:1]] : mem[pipe_a[lsel]]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else begin
            pipe_v    <= {pipe_v[2:0], mem_rd & ~mem_stall};
            pipe_a[0] <= mem_addr[10:1];
            pipe_a[1] <= pipe_a[0];
            pipe_a[2] <= pipe_a[1];
            pipe_a[3] <= pipe_a[2];
            if (mem_wr && !mem_stall) mem[mem_addr[10:1]] <= mem_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } acc_t;
    typedef struct packed { logic own_d; logic [1:0] beat; logic [DW-1:0] data; } rd_t;
    typedef struct packed { int c; logic own_d; } done_t;

    acc_t       exp_acc [$];
    rd_t        exp_rd  [$];
    done_t      done_log[$];
    logic [1:0] wbeat_log[$];
    acc_t       mon_a;
    rd_t        mon_r;
    done_t      mon_d;

    always @(negedge clk) begin
        if (!rst) begin
            if ((mem_rd || mem_wr) && !mem_stall) begin
                if (exp_acc.size() == 0) fail_now("unexpected_access");
                else begin
                    mon_a = exp_acc.pop_front();
                    chk("acc_addr", mem_addr, mon_a.addr);
                    chk("acc_kind", {mem_rd, mem_wr}, {~mon_a.wr, mon_a.wr});
                    if (mon_a.wr) chk("acc_wdata", mem_wdata, mon_a.wdata);
                end
            end
            if (mem_wr) wbeat_log.push_back(d_wbeat);
            if (i_rvalid && d_rvalid) fail_now("both_rvalid");
            else if (i_rvalid || d_rvalid) begin
                if (exp_rd.size() == 0) fail_now("unexpected_rvalid");
                else begin
                    mon_r = exp_rd.pop_front();
                    chk("rd_owner", d_rvalid, mon_r.own_d);
                    chk("rd_beat", d_rvalid ? d_rbeat : i_rbeat, mon_r.beat);
                    chk("rd_data", d_rvalid ? d_rdata : i_rdata, mon_r.data);
                end
            end
            if (i_done || d_done) begin
                if (i_done && d_done) fail_now("both_done");
                chk("busy_at_done", busy, 1);
                mon_d.c = cyc;
                mon_d.own_d = d_done;
                done_log.push_back(mon_d);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic own_d, input logic wr, input logic [AW-1:0] base);
        acc_t a;
        rd_t  r;
        for (int b = 0; b < 4; b++) begin
            a.wr    = wr;
            a.addr  = base + AW'(2 * b);
            a.wdata = wr ? wb_buf[b] : '0;
            exp_acc.push_back(a);
            if (!wr) begin
                r.own_d = own_d;
                r.beat  = 2'(b);
                r.data  = mem[10'(base[10:1] + 10'(b))];
                exp_rd.push_back(r);
            end
        end
    endtask

    task automatic wait_dones(input int n, input int limit);
        int k = 0;
        while (done_log.size() < n && k < limit) begin
            step();
            k++;
        end
        if (done_log.size() < n) fail_now("done_timeout");
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_req = 0; d_req = 0; d_wr = 0; mem_stall = 0; inj_rv = 0;
        step();
        step();
        rst = 1'b0;
        exp_acc.delete(); exp_rd.delete(); done_log.delete(); wbeat_log.delete();
    endtask

    typedef struct {
        logic          own_d;
        logic          wr;
        logic [AW-1:0] addr;
        int            mlat;
        logic [7:0]    smask;
        int            exp_cyc;
    } vec_t;

    task automatic run_one(input vec_t v, input int idx);
        int c0;
        lat = v.mlat;
        for (int b = 0; b < 4; b++) wb_buf[b] = 16'hA000 + 16'(idx * 16 + b);
        done_log.delete();
        wbeat_log.delete();
        push_burst(v.own_d, v.wr, v.addr);
        if (v.own_d) begin d_req = 1; d_wr = v.wr; d_addr = v.addr; end
        else         begin i_req = 1; i_addr = v.addr; end
        c0 = cyc;
        for (int k = 1; k <= 40 && done_log.size() == 0; k++) begin
            step();
            if (k == 1) begin
                // Requests and request fields change after grant; the burst must not care.
                i_req = 0; d_req = 0; d_wr = ~v.wr; d_addr = 16'hFFF8; i_addr = 16'hFFF8;
            end
            mem_stall = (k <= 8) ? v.smask[k-1] : 1'b0;
        end
        mem_stall = 0;
        if (done_log.size() == 0) fail_now($sformatf("v%0d_timeout", idx));
        else begin
            chk($sformatf("v%0d_done_cycle", idx), done_log[0].c - c0, v.exp_cyc);
            chk($sformatf("v%0d_done_owner", idx), done_log[0].own_d, v.own_d);
        end
        chk($sformatf("v%0d_busy_after", idx), busy, 0);
        chk($sformatf("v%0d_acc_left", idx), exp_acc.size(), 0);
        chk($sformatf("v%0d_rd_left", idx), exp_rd.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [6];
        vec_t       vx;
        logic [1:0] exp_wb [6];
        int         c0;

        i_addr = 0; d_addr = 0;
        for (int b = 0; b < 4; b++) wb_buf[b] = '0;
        //          own_d wr  addr      lat mask         exp done cycle
        vecs[0] = '{1'b0, 1'b0, 16'h0040, 1, 8'b0000_0000, 6};
        vecs[1] = '{1'b1, 1'b1, 16'h0100, 1, 8'b0000_0110, 7};
        vecs[2] = '{1'b1, 1'b0, 16'h0300, 2, 8'b0000_0001, 8};
        vecs[3] = '{1'b0, 1'b0, 16'h0080, 0, 8'b0000_0000, 5};
        vecs[4] = '{1'b1, 1'b1, 16'h0208, 1, 8'b0000_1000, 6};
        vecs[5] = '{1'b0, 1'b0, 16'h00F8, 3, 8'b0000_0101, 10};
        exp_wb  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

        apply_reset();
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_rd, mem_wr}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", {i_done, d_done}, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rst_d_wbeat", d_wbeat, 0);

        for (int v = 0; v < 6; v++) begin
            run_one(vecs[v], v);
            if (v == 1) begin
                chk("wb_log_len", wbeat_log.size(), 6);
                for (int j = 0; j < 6 && j < wbeat_log.size(); j++)
                    chk($sformatf("wb_beat_%0d", j), wbeat_log[j], exp_wb[j]);
            end
            step();
        end

        // Tie out of reset: D first, then I in the IDLE cycle after d_done.
        apply_reset();
        lat = 1;
        push_burst(1'b1, 1'b0, 16'h0200);
        push_burst(1'b0, 1'b0, 16'h0020);
        d_req = 1; d_wr = 0; d_addr = 16'h0200; i_req = 1; i_addr = 16'h0020;
        c0 = cyc;
        step();
        d_req = 0;
        wait_dones(2, 60);
        i_req = 0;
        if (done_log.size() >= 2) begin
            chk("tie1_first_owner", done_log[0].own_d, 1);
            chk("tie1_first_cycle", done_log[0].c - c0, 6);
            chk("tie1_second_owner", done_log[1].own_d, 0);
            chk("tie1_second_cycle", done_log[1].c - c0, 13);
        end
        // After the I burst last_d is 0, so another tie goes to D.
        step();
        done_log.delete();
        push_burst(1'b1, 1'b0, 16'h0240);
        d_req = 1; d_addr = 16'h0240; i_req = 1; i_addr = 16'h0060;
        c0 = cyc;
        step();
        d_req = 0; i_req = 0;
        wait_dones(1, 40);
        if (done_log.size() >= 1) begin
            chk("tie2_owner", done_log[0].own_d, 1);
            chk("tie2_cycle", done_log[0].c - c0, 6);
        end
        step();

        // Back-to-back D fills with d_req held, then I wins the next tie.
        done_log.delete();
        push_burst(1'b1, 1'b0, 16'h0280);
        d_req = 1; d_wr = 0; d_addr = 16'h0280;
        c0 = cyc;
        step();
        d_addr = 16'h02C0;
        push_burst(1'b1, 1'b0, 16'h02C0);
        wait_dones(1, 40);
        step();
        i_req = 1; i_addr = 16'h00A0;
        push_burst(1'b0, 1'b0, 16'h00A0);
        wait_dones(2, 40);
        step();
        d_req = 0;
        wait_dones(3, 40);
        i_req = 0;
        if (done_log.size() >= 3) begin
            chk("b2b_first_cycle", done_log[0].c - c0, 6);
            chk("b2b_second_owner", done_log[1].own_d, 1);
            chk("b2b_second_cycle", done_log[1].c - c0, 13);
            chk("b2b_third_owner", done_log[2].own_d, 0);
            chk("b2b_third_cycle", done_log[2].c - c0, 20);
        end
        chk("b2b_acc_left", exp_acc.size(), 0);
        step();

        // Reset while an I fill is draining.
        lat = 3;
        done_log.delete();
        push_burst(1'b0, 1'b0, 16'h00C0);
        i_req = 1; i_addr = 16'h00C0;
        step();
        i_req = 0;
        for (int k = 0; k < 5; k++) step();
        chk("drain_busy_before_rst", busy, 1);
        rst = 1;
        step();
        rst = 0;
        exp_acc.delete(); exp_rd.delete();
        inj_rv = 1;
        #1;
        chk("drain_rst_busy", busy, 0);
        chk("drain_rst_i_rvalid", i_rvalid, 0);
        chk("drain_rst_i_rdata", i_rdata, 0);
        chk("drain_rst_strobes", {mem_rd, mem_wr}, 0);
        chk("drain_rst_done", {i_done, d_done}, 0);
        step();
        inj_rv = 0;
        chk("drain_rst_no_done", done_log.size(), 0);
        vx = '{1'b1, 1'b1, 16'h0180, 1, 8'b0000_0000, 5};
        run_one(vx, 6);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
